// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full_adder, LSB first, one bit per clock; start/busy/done handshake.
// Accept edge T -> done pulse in the cycle after edge T+WIDTH; start is ignored while busy.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_c;
  logic w_last;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_c),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_part  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
          r_part <= {w_s, r_part[WIDTH-1:1]};
          r_c    <= w_c;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_sum   <= {w_s, r_part[WIDTH-1:1]};
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=2 instances, table vectors, corner sequences, random vs a+b+cin.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((busy8 === 1'b1 && done8 === 1'b1) || (busy2 === 1'b1 && done2 === 1'b1)) begin
      nmis++;
      $display("FAIL busy_done_overlap at cycle %0d: busy8=%b done8=%b busy2=%b done2=%b, required never both high",
               cyc, busy8, done8, busy2, done2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, scramble inputs, then wait (bounded) for done.
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv, input logic ci,
                        output logic [63:0] s, output logic co, output logic [63:0] s_run,
                        output int lat, output int nb);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; start8 = 1'b1;
    end else begin
      a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci; start2 = 1'b1;
    end
    step();
    start8 = 1'b0; start2 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
    s_run = (w == 8) ? 64'(sum8) : 64'(sum2);
    lat = 1;
    nb  = 0;
    while (!((w == 8) ? done8 : done2) && lat < 64) begin
      if ((w == 8) ? busy8 : busy2) nb++;
      step();
      lat++;
    end
    s  = (w == 8) ? 64'(sum8) : 64'(sum2);
    co = (w == 8) ? cout8 : cout2;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [63:0] s, s_run, prev8, prev2;
    logic        co;
    int          lat, nb, ndone, t0, t1, t2, full;
    logic [63:0] ra, rb;
    logic        rc;

    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

    step(); step(); step();
    chk("reset_busy", 64'(busy8), 0);
    chk("reset_done", 64'(done8), 0);
    chk("reset_sum", 64'(sum8), 0);
    chk("reset_cout", 64'(cout8), 0);
    chk("reset_sum_w2", 64'(sum2), 0);
    rst = 1'b0;
    step();

    prev8 = 0;
    foreach (tbl[i]) begin
      run_op(8, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, s, co, s_run, lat, nb);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 9);
      chk($sformatf("tbl%0d_busy_cycles", i), 64'(nb), 8);
      chk($sformatf("tbl%0d_sum_held_in_run", i), s_run, prev8);
      chk($sformatf("tbl%0d_sum", i), s, 64'(tbl[i].s));
      chk($sformatf("tbl%0d_cout", i), 64'(co), 64'(tbl[i].co));
      prev8 = 64'(tbl[i].s);
      step();
      chk($sformatf("tbl%0d_done_one_cycle", i), 64'(done8), 0);
      chk($sformatf("tbl%0d_idle_busy", i), 64'(busy8), 0);
    end

    // start during RUN with new operands must be ignored
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8) ndone++;
      step();
    end
    chk("run_start_done_count", 64'(ndone), 1);
    chk("run_start_sum", 64'(sum8), 64'h33);
    chk("run_start_cout", 64'(cout8), 0);

    // start held high: back-to-back operations
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    step();
    t0 = cyc;
    wait_done8();
    t1 = cyc;
    chk("b2b_first_latency", 64'(t1 - t0), 8);
    chk("b2b_first_sum", 64'(sum8), 64'h03);
    a8 = 8'h10; b8 = 8'h20;
    step();
    wait_done8();
    t2 = cyc;
    chk("b2b_done_spacing", 64'(t2 - t1), 9);
    chk("b2b_second_sum", 64'(sum8), 64'h30);
    start8 = 1'b0;
    step();
    chk("b2b_idle_busy", 64'(busy8), 0);
    chk("b2b_idle_done", 64'(done8), 0);

    // reset in the middle of RUN
    a8 = 8'h44; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy8), 0);
    chk("midrst_done", 64'(done8), 0);
    chk("midrst_sum", 64'(sum8), 0);
    chk("midrst_cout", 64'(cout8), 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) ndone++;
      step();
    end
    chk("midrst_no_activity", 64'(ndone), 0);
    run_op(8, 64'h3C, 64'h5A, 1'b0, s, co, s_run, lat, nb);
    chk("postrst_latency", 64'(lat), 9);
    chk("postrst_sum_held", s_run, 0);
    chk("postrst_sum", s, 64'h96);
    chk("postrst_cout", 64'(co), 0);
    prev8 = 64'h96;

    // WIDTH=2 corner
    prev2 = 0;
    run_op(2, 64'd3, 64'd3, 1'b1, s, co, s_run, lat, nb);
    chk("w2_latency", 64'(lat), 3);
    chk("w2_busy_cycles", 64'(nb), 2);
    chk("w2_sum", s, 64'd3);
    chk("w2_cout", 64'(co), 1);
    prev2 = 3;

    // random WIDTH=2 against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = 64'($urandom_range(0, 3));
      rb = 64'($urandom_range(0, 3));
      rc = 1'($urandom);
      full = int'(ra) + int'(rb) + int'(rc);
      run_op(2, ra, rb, rc, s, co, s_run, lat, nb);
      chk("w2_rand_held", s_run, prev2);
      chk("w2_rand_sum", s, 64'(full % 4));
      chk("w2_rand_cout", 64'(co), 64'(full / 4));
      prev2 = 64'(full % 4);
    end

    // random WIDTH=8 against plain arithmetic
    for (int i = 0; i < 200; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      rc = 1'($urandom);
      full = int'(ra) + int'(rb) + int'(rc);
      run_op(8, ra, rb, rc, s, co, s_run, lat, nb);
      chk("w8_rand_latency", 64'(lat), 9);
      chk("w8_rand_held", s_run, prev8);
      chk("w8_rand_sum", s, 64'(full % 256));
      chk("w8_rand_cout", 64'(co), 64'(full / 256));
      prev8 = 64'(full % 256);
    end

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
